// File: rtl/fft_uart_sequencer_pkg.sv
// fft_uart_sequencer_pkg: state encoding and width helpers shared by the frame sequencer.
package fft_uart_sequencer_pkg;

    typedef enum logic [2:0] {
        RECV,
        WAIT_FFT,
        READ,
        SEND,
        WAIT_TX
    } state_t;

    localparam int BYTES_PER_BIN = 4;
    localparam int BYTE_W        = $clog2(BYTES_PER_BIN);

    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/fft_uart_sequencer_seq_timeout_counter.sv
// seq_timeout_counter: loadable down-counter; expired stays high once an armed count reaches zero.
module seq_timeout_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;
    logic         active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (clear) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= load_val;
            active <= 1'b1;
        end else if (active && cnt != '0) begin
            cnt    <= cnt - 1'b1;
        end
    end

    assign expired = active && cnt == '0;

endmodule

// File: rtl/fft_uart_sequencer.sv
// fft_uart_sequencer: collects UART sample bytes into the FFT input buffer, runs the FFT,
// and streams every result bin back out over UART as four bytes, recovering from timeouts.
module fft_uart_sequencer
    import fft_uart_sequencer_pkg::*;
#(
    parameter int FFT_SIZE    = 16,
    parameter int WORD_SIZE   = 16,
    parameter int DATA_LENGTH = 8,
    parameter int FRACTION    = 8,
    parameter int RX_TIMEOUT  = 4096,
    parameter int FFT_TIMEOUT = 1024
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_rx_valid,
    input  logic [DATA_LENGTH-1:0]      i_rx_byte,
    input  logic                        i_rx_error,
    output logic                        o_smp_wr,
    output logic [$clog2(FFT_SIZE)-1:0] o_smp_addr,
    output logic [WORD_SIZE-1:0]        o_smp_data,
    output logic                        o_fft_rst,
    output logic                        o_fft_start,
    input  logic                        i_fft_done,
    output logic [$clog2(FFT_SIZE)-1:0] o_res_addr,
    input  logic [WORD_SIZE-1:0]        i_res_re,
    input  logic [WORD_SIZE-1:0]        i_res_im,
    output logic                        o_tx_start,
    output logic [DATA_LENGTH-1:0]      o_tx_byte,
    input  logic                        i_tx_done,
    output logic                        o_busy,
    output logic                        o_frame_done,
    output logic                        o_error
);

    localparam int AW  = $clog2(FFT_SIZE);
    localparam int RXW = cnt_width(RX_TIMEOUT);
    localparam int FTW = cnt_width(FFT_TIMEOUT);
    localparam logic [AW-1:0]     LAST      = AW'(FFT_SIZE - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES_PER_BIN - 1);

    state_t                 state_q, state_d;
    logic [AW-1:0]          count, bin;
    logic [BYTE_W-1:0]      byte_idx;
    logic                   rd_phase;
    logic [2*WORD_SIZE-1:0] shreg;
    logic [WORD_SIZE-1:0]   ext;
    logic in_recv, last_wr, disc, complete, acc, fft_ok, fft_to;
    logic rx_exp, fft_exp, tx_adv, byte_last, bin_last, frame_end;

    assign in_recv   = state_q == RECV;
    // The last sample's write strobe doubles as the frame-complete marker, so no extra flag.
    assign last_wr   = o_smp_wr && o_smp_addr == LAST;
    assign disc      = in_recv && (i_rx_error || rx_exp);
    assign complete  = in_recv && !disc && last_wr;
    assign acc       = in_recv && i_rx_valid && !disc && !last_wr;
    assign fft_ok    = state_q == WAIT_FFT && i_fft_done;
    assign fft_to    = state_q == WAIT_FFT && !i_fft_done && fft_exp;
    assign tx_adv    = state_q == WAIT_TX && i_tx_done;
    assign byte_last = byte_idx == LAST_BYTE;
    assign bin_last  = bin == LAST;
    assign frame_end = tx_adv && byte_last && bin_last;
    assign ext       = WORD_SIZE'($signed(i_rx_byte)) << FRACTION;

    seq_timeout_counter #(.W(RXW)) u_rx_timer (
        .clk      (i_clk),
        .rst_n    (i_rst),
        .load     (acc),
        .clear    (disc || complete || !in_recv),
        .load_val (RXW'(RX_TIMEOUT - 1)),
        .expired  (rx_exp)
    );

    seq_timeout_counter #(.W(FTW)) u_fft_timer (
        .clk      (i_clk),
        .rst_n    (i_rst),
        .load     (complete),
        .clear    (fft_ok || fft_to),
        .load_val (FTW'(FFT_TIMEOUT - 1)),
        .expired  (fft_exp)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state_q <= RECV;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RECV:     state_d = complete ? WAIT_FFT : RECV;
            WAIT_FFT: state_d = i_fft_done ? READ : (fft_exp ? RECV : WAIT_FFT);
            READ:     state_d = rd_phase ? SEND : READ;
            SEND:     state_d = WAIT_TX;
            WAIT_TX:  state_d = !i_tx_done ? WAIT_TX : (!byte_last ? SEND : (bin_last ? RECV : READ));
            default:  state_d = RECV;
        endcase
    end

    always_comb begin
        o_busy     = !in_recv;
        o_res_addr = (state_q == READ && !rd_phase) ? bin : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            count        <= '0;
            bin          <= '0;
            byte_idx     <= '0;
            rd_phase     <= 1'b0;
            shreg        <= '0;
            o_smp_wr     <= 1'b0;
            o_smp_addr   <= '0;
            o_smp_data   <= '0;
            o_fft_rst    <= 1'b1;
            o_fft_start  <= 1'b0;
            o_tx_start   <= 1'b0;
            o_tx_byte    <= '0;
            o_frame_done <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            o_smp_wr     <= acc;
            o_fft_start  <= complete;
            o_tx_start   <= state_q == SEND;
            o_error      <= disc || fft_to;
            o_frame_done <= frame_end;
            o_fft_rst    <= disc || fft_to || frame_end;
            rd_phase     <= state_q == READ && !rd_phase;
            if (acc) begin
                o_smp_addr <= count;
                o_smp_data <= ext;
            end
            if (disc) count <= '0;
            else if (acc) count <= (count == LAST) ? '0 : count + 1'b1;
            if (fft_ok) bin <= '0;
            if (state_q == READ && rd_phase) shreg <= {i_res_re, i_res_im};
            if (state_q == SEND) begin
                o_tx_byte <= shreg[2*WORD_SIZE-1 -: DATA_LENGTH];
                shreg     <= shreg << DATA_LENGTH;
            end
            if (tx_adv) begin
                byte_idx <= byte_last ? '0 : byte_idx + 1'b1;
                if (byte_last) bin <= bin_last ? '0 : bin + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_uart_sequencer.sv
// tb_fft_uart_sequencer: drives UART sample frames, models the FFT core and UART_TX, and checks
// writes, TX byte stream, pulses and recovery against a frame-level reference model.
module tb_fft_uart_sequencer;

    localparam int N   = 16;
    localparam int AW  = 4;
    localparam int RXT = 4096;
    localparam int FT  = 1024;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_rx_valid = 1'b0;
    logic [7:0]    i_rx_byte = '0;
    logic          i_rx_error = 1'b0;
    logic          o_smp_wr;
    logic [AW-1:0] o_smp_addr;
    logic [15:0]   o_smp_data;
    logic          o_fft_rst;
    logic          o_fft_start;
    logic          i_fft_done;
    logic [AW-1:0] o_res_addr;
    logic [15:0]   i_res_re, i_res_im;
    logic          o_tx_start;
    logic [7:0]    o_tx_byte;
    logic          i_tx_done;
    logic          o_busy, o_frame_done, o_error;

    fft_uart_sequencer dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx_valid(i_rx_valid), .i_rx_byte(i_rx_byte),
        .i_rx_error(i_rx_error), .o_smp_wr(o_smp_wr), .o_smp_addr(o_smp_addr),
        .o_smp_data(o_smp_data), .o_fft_rst(o_fft_rst), .o_fft_start(o_fft_start),
        .i_fft_done(i_fft_done), .o_res_addr(o_res_addr), .i_res_re(i_res_re),
        .i_res_im(i_res_im), .o_tx_start(o_tx_start), .o_tx_byte(o_tx_byte),
        .i_tx_done(i_tx_done), .o_busy(o_busy), .o_frame_done(o_frame_done), .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0, n_fail = 0;
    int fft_delay = 50, tx_lat = 6;
    logic [7:0]  smp[N];
    logic [15:0] mem_re[N], mem_im[N];
    logic [15:0] re_q, im_q;

    // FFT result memory: one-cycle registered read
    always @(posedge i_clk) begin
        re_q <= mem_re[o_res_addr];
        im_q <= mem_im[o_res_addr];
    end
    assign i_res_re = re_q;
    assign i_res_im = im_q;

    initial begin
        i_fft_done = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_fft_start && fft_delay >= 0) begin
                repeat (fft_delay) @(posedge i_clk);
                #1 i_fft_done = 1'b1;
                @(posedge i_clk);
                #1 i_fft_done = 1'b0;
            end
        end
    end

    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_tx_start) begin
                repeat (tx_lat) @(posedge i_clk);
                #1 i_tx_done = 1'b1;
                @(posedge i_clk);
                #1 i_tx_done = 1'b0;
            end
        end
    end

    int cyc = 0, start_cnt = 0, err_cnt = 0, fd_cnt = 0, frst_cnt = 0, overlap_cnt = 0;
    int start_cyc = 0, err_cyc = 0, last_wr_cyc = 0;
    bit outst = 1'b0;
    logic [AW-1:0] wr_addr_q[$];
    logic [15:0]   wr_data_q[$];
    logic [7:0]    tx_q[$];

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (i_rst) begin
            if (o_smp_wr) begin
                wr_addr_q.push_back(o_smp_addr);
                wr_data_q.push_back(o_smp_data);
                last_wr_cyc <= cyc;
            end
            if (o_fft_start) begin
                start_cnt <= start_cnt + 1;
                start_cyc <= cyc;
            end
            if (o_error) begin
                err_cnt <= err_cnt + 1;
                err_cyc <= cyc;
            end
            if (o_frame_done) fd_cnt <= fd_cnt + 1;
            if (o_fft_rst) frst_cnt <= frst_cnt + 1;
            if (o_tx_start) begin
                tx_q.push_back(o_tx_byte);
                if (outst) overlap_cnt <= overlap_cnt + 1;
            end
        end
        outst <= !i_rst ? 1'b0 : (o_tx_start ? 1'b1 : (i_tx_done ? 1'b0 : outst));
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge i_clk);
        #1 i_rx_valid = 1'b1;
        i_rx_byte = b;
        @(posedge i_clk);
        #1 i_rx_valid = 1'b0;
        repeat ($urandom_range(8, 20)) @(posedge i_clk);
    endtask

    task automatic randomize_frame(input bit zero_bins);
        for (int i = 0; i < N; i++) begin
            smp[i]    = 8'($urandom_range(0, 255));
            mem_re[i] = zero_bins ? 16'h0 : 16'($urandom_range(0, 65535));
            mem_im[i] = zero_bins ? 16'h0 : 16'($urandom_range(0, 65535));
        end
    endtask

    // Sends smp[], optionally injects bytes while busy, and checks the whole frame outcome.
    task automatic run_frame(input string name, input int extra);
        int fd0 = fd_cnt, e0 = err_cnt, r0 = frst_cnt, k = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
        tx_q.delete();
        for (int i = 0; i < N; i++) send_byte(smp[i]);
        while (!o_busy && k < 2000) begin @(posedge i_clk); k++; end
        for (int i = 0; i < extra; i++) send_byte(8'($urandom_range(0, 255)));
        k = 0;
        while (fd_cnt == fd0 && k < 20000) begin @(posedge i_clk); k++; end
        #1;
        n_tests++;
        if (fd_cnt != fd0 + 1) begin n_fail++; $display("FAIL %s frame_done: got %0d pulses expected 1", name, fd_cnt - fd0); end
        n_tests++;
        if (wr_addr_q.size() != N) begin
            n_fail++; $display("FAIL %s write_count: got %0d expected %0d", name, wr_addr_q.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                int s;
                logic [15:0] exp_d;
                s = smp[i] >= 128 ? int'(smp[i]) - 256 : int'(smp[i]);
                exp_d = 16'(s * 256);
                n_tests++;
                if (wr_addr_q[i] !== AW'(i)) begin n_fail++; $display("FAIL %s wr_addr[%0d]: got %0d expected %0d", name, i, wr_addr_q[i], i); end
                n_tests++;
                if (wr_data_q[i] !== exp_d) begin n_fail++; $display("FAIL %s wr_data[%0d]: got %h expected %h", name, i, wr_data_q[i], exp_d); end
            end
        end
        n_tests++;
        if (start_cyc - last_wr_cyc != 1) begin n_fail++; $display("FAIL %s start_latency: got %0d expected 1", name, start_cyc - last_wr_cyc); end
        n_tests++;
        if (tx_q.size() != 4 * N) begin
            n_fail++; $display("FAIL %s tx_count: got %0d expected %0d", name, tx_q.size(), 4 * N);
        end else begin
            for (int b = 0; b < 4 * N; b++) begin
                logic [15:0] v;
                logic [7:0]  eb;
                v  = (b % 4 < 2) ? mem_re[b / 4] : mem_im[b / 4];
                eb = (b % 2 == 0) ? 8'(v / 256) : 8'(v % 256);
                n_tests++;
                if (tx_q[b] !== eb) begin n_fail++; $display("FAIL %s tx_byte[%0d]: got %h expected %h", name, b, tx_q[b], eb); end
            end
        end
        n_tests++;
        if (err_cnt != e0) begin n_fail++; $display("FAIL %s error_pulses: got %0d expected 0", name, err_cnt - e0); end
        n_tests++;
        if (frst_cnt != r0 + 1) begin n_fail++; $display("FAIL %s fft_rst_pulses: got %0d expected 1", name, frst_cnt - r0); end
        n_tests++;
        if (overlap_cnt != 0) begin n_fail++; $display("FAIL %s tx_overlap: got %0d expected 0", name, overlap_cnt); end
        n_tests++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after: got %b expected 0", name, o_busy); end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [47:0] zeros;
        zeros = {o_smp_wr, o_smp_addr, o_smp_data, o_fft_start, o_res_addr, o_tx_start,
                 o_tx_byte, o_busy, o_frame_done, o_error, 6'b0};
        n_tests++;
        if (zeros !== '0) begin n_fail++; $display("FAIL %s outputs_zero: got %h expected 0", name, zeros); end
        n_tests++;
        if (o_fft_rst !== 1'b1) begin n_fail++; $display("FAIL %s fft_rst: got %b expected 1", name, o_fft_rst); end
    endtask

    task automatic test_reset();
        #12;
        check_reset_outputs("reset");
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        n_tests++;
        if (o_fft_rst !== 1'b0) begin n_fail++; $display("FAIL reset_release fft_rst: got %b expected 0", o_fft_rst); end
    endtask

    task automatic test_basic_frame();
        fft_delay = 50;
        for (int i = 0; i < N; i++) begin
            smp[i]    = 8'(i + 1);
            mem_re[i] = 16'h0;
            mem_im[i] = 16'h0;
        end
        mem_re[0] = 16'h1234;
        mem_im[0] = 16'hFEDC;
        run_frame("basic", 0);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            fft_delay = $urandom_range(1, 100);
            tx_lat    = $urandom_range(1, 10);
            randomize_frame(1'b0);
            run_frame("back_to_back", f);
        end
        tx_lat = 6;
    endtask

    task automatic test_rx_timeout();
        int e0 = err_cnt, r0 = frst_cnt;
        wr_addr_q.delete();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)));
        repeat (RXT + 10) @(posedge i_clk);
        #1;
        n_tests++;
        if (err_cnt != e0 + 1) begin n_fail++; $display("FAIL rx_timeout error_pulses: got %0d expected 1", err_cnt - e0); end
        n_tests++;
        if (frst_cnt != r0 + 1) begin n_fail++; $display("FAIL rx_timeout fft_rst_pulses: got %0d expected 1", frst_cnt - r0); end
        n_tests++;
        if (wr_addr_q.size() != 5) begin n_fail++; $display("FAIL rx_timeout partial_writes: got %0d expected 5", wr_addr_q.size()); end
        randomize_frame(1'b1);
        for (int i = 0; i < N; i++) smp[i] = 8'h02;
        run_frame("after_rx_timeout", 0);
    endtask

    task automatic test_fft_timeout();
        int e0 = err_cnt, r0 = frst_cnt, s0 = start_cnt, k = 0;
        fft_delay = -1;
        tx_q.delete();
        randomize_frame(1'b0);
        for (int i = 0; i < N; i++) send_byte(smp[i]);
        while (err_cnt == e0 && k < FT + 500) begin @(posedge i_clk); k++; end
        repeat (3) @(posedge i_clk);
        #1;
        n_tests++;
        if (start_cnt != s0 + 1) begin n_fail++; $display("FAIL fft_timeout start_pulses: got %0d expected 1", start_cnt - s0); end
        n_tests++;
        if (err_cnt != e0 + 1) begin n_fail++; $display("FAIL fft_timeout error_pulses: got %0d expected 1", err_cnt - e0); end
        n_tests++;
        if (err_cyc - start_cyc != FT) begin n_fail++; $display("FAIL fft_timeout latency: got %0d expected %0d", err_cyc - start_cyc, FT); end
        n_tests++;
        if (frst_cnt != r0 + 1) begin n_fail++; $display("FAIL fft_timeout fft_rst_pulses: got %0d expected 1", frst_cnt - r0); end
        n_tests++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL fft_timeout busy: got %b expected 0", o_busy); end
        n_tests++;
        if (tx_q.size() != 0) begin n_fail++; $display("FAIL fft_timeout tx_count: got %0d expected 0", tx_q.size()); end
        fft_delay = 30;
        randomize_frame(1'b0);
        run_frame("after_fft_timeout", 0);
    endtask

    task automatic test_rx_error();
        int e0 = err_cnt, r0 = frst_cnt;
        for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(0, 255)));
        @(posedge i_clk);
        #1 i_rx_error = 1'b1;
        @(posedge i_clk);
        #1 i_rx_error = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        n_tests++;
        if (err_cnt != e0 + 1) begin n_fail++; $display("FAIL rx_error error_pulses: got %0d expected 1", err_cnt - e0); end
        n_tests++;
        if (frst_cnt != r0 + 1) begin n_fail++; $display("FAIL rx_error fft_rst_pulses: got %0d expected 1", frst_cnt - r0); end
        randomize_frame(1'b0);
        run_frame("after_rx_error", 0);
    endtask

    task automatic test_reset_mid_tx();
        int k = 0, starts = 0;
        fft_delay = 20;
        randomize_frame(1'b0);
        tx_q.delete();
        for (int i = 0; i < N; i++) send_byte(smp[i]);
        while (tx_q.size() < 14 && k < 5000) begin @(posedge i_clk); k++; end
        n_tests++;
        if (tx_q.size() < 14) begin n_fail++; $display("FAIL reset_mid_tx reach_bin3: got %0d bytes expected 14", tx_q.size()); end
        @(negedge i_clk);
        #2 i_rst = 1'b0;
        #1;
        check_reset_outputs("reset_mid_tx");
        for (int c = 0; c < 10; c++) begin
            @(posedge i_clk);
            #1 if (o_tx_start) starts++;
        end
        i_rst = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge i_clk);
            #1 if (o_tx_start) starts++;
        end
        n_tests++;
        if (starts != 0) begin n_fail++; $display("FAIL reset_mid_tx tx_start_after: got %0d expected 0", starts); end
        randomize_frame(1'b0);
        run_frame("after_reset", 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            mem_re[i] = 16'h0;
            mem_im[i] = 16'h0;
        end
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_rx_timeout();
        test_fft_timeout();
        test_rx_error();
        test_reset_mid_tx();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
